// File: rtl/reg_hazard_scoreboard_if.sv
// Issue-side bundle between the decode/control unit and the register hazard scoreboard.
// The master drives the instruction fields and ex_ready; the slave returns issue and status.
interface reg_hazard_scoreboard_if #(
  parameter int NREG = 16,
  parameter int AW   = 4
);
  logic            id_valid;
  logic [1:0]      rsel;
  logic [AW-1:0]   ra2;
  logic [AW-1:0]   ra3;
  logic [AW-1:0]   wa;
  logic            we_dst;
  logic            ex_ready;
  logic            id_ready;
  logic            iss_fire;
  logic            stall;
  logic [NREG-1:0] busy_mask;
  logic [15:0]     stall_cycles;

  modport master (
    output id_valid, rsel, ra2, ra3, wa, we_dst, ex_ready,
    input  id_ready, iss_fire, stall, busy_mask, stall_cycles
  );

  modport slave (
    input  id_valid, rsel, ra2, ra3, wa, we_dst, ex_ready,
    output id_ready, iss_fire, stall, busy_mask, stall_cycles
  );
endinterface

// File: rtl/reg_hazard_scoreboard.sv
// Decode-stage RAW interlock: per-register countdowns track in-flight writes and
// hold issue until every source the instruction actually reads has been written back.
module reg_hazard_scoreboard #(
  parameter int NREG   = 16,
  parameter int AW     = 4,
  parameter int WB_LAT = 3
) (
  input logic                   clk,
  input logic                   rst,
  reg_hazard_scoreboard_if.slave bus
);

  localparam logic [2:0]  LAT     = 3'(WB_LAT);
  localparam logic [15:0] SC_MAX  = 16'hFFFF;

  logic [2:0]  cnt_q [NREG];
  logic [2:0]  cnt_d [NREG];
  logic [15:0] stall_cycles_q;
  logic [15:0] stall_cycles_d;

  logic use2;
  logic use3;
  logic hazard;
  logic id_ready;
  logic iss_fire;
  logic stall;

  // Hazard uses the counters as they stand this cycle, so a self-dependent
  // instruction sees the previous writer and still issues.
  always_comb begin
    use2     = bus.rsel[1];
    use3     = bus.rsel[0];
    hazard   = (use2 && (cnt_q[bus.ra2] != 3'd0)) ||
               (use3 && (cnt_q[bus.ra3] != 3'd0));
    id_ready = !hazard && bus.ex_ready;
    iss_fire = bus.id_valid && id_ready;
    stall    = bus.id_valid && hazard;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (iss_fire && bus.we_dst && (bus.wa == AW'(r))) begin
        cnt_d[r] = LAT;
      end else if (bus.ex_ready && (cnt_q[r] != 3'd0)) begin
        cnt_d[r] = cnt_q[r] - 3'd1;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != SC_MAX)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= 3'd0;
      end
      stall_cycles_q <= 16'd0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      bus.busy_mask[r] = (cnt_q[r] != 3'd0);
    end
  end

  assign bus.id_ready     = id_ready;
  assign bus.iss_fire     = iss_fire;
  assign bus.stall        = stall;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Directed bench for reg_hazard_scoreboard with WB_LAT=3: expectations are queued
// as each cycle's stimulus is driven and popped when the outputs are sampled.
module tb_reg_hazard_scoreboard;

  localparam int NREG = 16;
  localparam int AW   = 4;

  logic clk;
  logic rst;

  reg_hazard_scoreboard_if #(.NREG(NREG), .AW(AW)) bus ();

  reg_hazard_scoreboard #(.NREG(NREG), .AW(AW), .WB_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        st;
    logic        fi;
    logic        rd;
    logic [15:0] bm;
    logic [15:0] sc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] sc_exp = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic st, input logic fi,
                          input logic rd, input logic [15:0] bm);
    exp_t e;
    e.tag = tag; e.st = st; e.fi = fi; e.rd = rd; e.bm = bm; e.sc = sc_exp;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".stall"},        32'(bus.stall),        32'(e.st));
    chk({e.tag, ".iss_fire"},     32'(bus.iss_fire),     32'(e.fi));
    chk({e.tag, ".id_ready"},     32'(bus.id_ready),     32'(e.rd));
    chk({e.tag, ".busy_mask"},    32'(bus.busy_mask),    32'(e.bm));
    chk({e.tag, ".stall_cycles"}, 32'(bus.stall_cycles), 32'(e.sc));
  endtask

  task automatic drive(input logic v, input logic [1:0] rs, input logic [3:0] a2,
                       input logic [3:0] a3, input logic [3:0] w, input logic we,
                       input logic exr);
    bus.id_valid = v;
    bus.rsel     = rs;
    bus.ra2      = a2;
    bus.ra3      = a3;
    bus.wa       = w;
    bus.we_dst   = we;
    bus.ex_ready = exr;
  endtask

  // One clock cycle: drive at the falling edge, check mid-low-phase, advance.
  task automatic step(input string tag, input logic v, input logic [1:0] rs,
                      input logic [3:0] a2, input logic [3:0] a3, input logic [3:0] w,
                      input logic we, input logic exr,
                      input logic e_st, input logic e_fi, input logic e_rd,
                      input logic [15:0] e_bm);
    drive(v, rs, a2, a3, w, we, exr);
    push_exp(tag, e_st, e_fi, e_rd, e_bm);
    #1;
    check_pop();
    if (e_st) sc_exp = sc_exp + 16'd1;
    @(negedge clk);
  endtask

  function automatic logic [15:0] B(input int r);
    return 16'(1) << r;
  endfunction

  initial begin
    logic v_r;
    logic e_r;
    rst = 1'b0;
    drive(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);

    // Reset held with random stimulus: nothing may be recorded.
    for (int i = 0; i < 3; i++) begin
      v_r = 1'($urandom_range(0, 1));
      e_r = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(v_r, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
            1'b1, e_r);
      push_exp("reset", 1'b0, v_r & e_r, e_r, 16'h0000);
      #1;
      check_pop();
      @(negedge clk);
    end
    rst = 1'b1;
    step("rst_idle", 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0000);

    // Back-to-back RAW on r5.
    step("raw_c0", 1, 2'b00, 0, 0, 5, 1, 1, 0, 1, 1, 16'h0000);
    step("raw_c1", 1, 2'b10, 5, 0, 0, 0, 1, 1, 0, 0, B(5));
    step("raw_c2", 1, 2'b10, 5, 0, 0, 0, 1, 1, 0, 0, B(5));
    step("raw_c3", 1, 2'b10, 5, 0, 0, 0, 1, 1, 0, 0, B(5));
    step("raw_c4", 1, 2'b10, 5, 0, 0, 0, 1, 0, 1, 1, 16'h0000);

    // Busy registers on unused source fields do not stall.
    step("unu_wr",  1, 2'b00, 0, 0, 5, 1, 1, 0, 1, 1, 16'h0000);
    step("unu_00",  1, 2'b00, 5, 5, 0, 0, 1, 0, 1, 1, B(5));
    step("unu_10",  1, 2'b10, 6, 5, 0, 0, 1, 0, 1, 1, B(5));
    step("unu_idl", 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1, B(5));

    // R3-only path, then both sources aliased to the same busy register.
    step("r3_wr",  1, 2'b00, 0, 0, 7, 1, 1, 0, 1, 1, 16'h0000);
    step("r3_s1",  1, 2'b01, 2, 7, 7, 1, 1, 1, 0, 0, B(7));
    step("r3_s2",  1, 2'b01, 2, 7, 7, 1, 1, 1, 0, 0, B(7));
    step("r3_s3",  1, 2'b01, 2, 7, 7, 1, 1, 1, 0, 0, B(7));
    step("r3_iss", 1, 2'b01, 2, 7, 7, 1, 1, 0, 1, 1, 16'h0000);
    step("r23_s1", 1, 2'b11, 7, 7, 0, 0, 1, 1, 0, 0, B(7));
    step("r23_s2", 1, 2'b11, 7, 7, 0, 0, 1, 1, 0, 0, B(7));
    step("r23_s3", 1, 2'b11, 7, 7, 0, 0, 1, 1, 0, 0, B(7));
    step("r23_is", 1, 2'b11, 7, 7, 0, 0, 1, 0, 1, 1, 16'h0000);

    // Backpressure freezes the r3 countdown for two cycles.
    step("bp_wr",  1, 2'b00, 0, 0, 3, 1, 1, 0, 1, 1, 16'h0000);
    step("bp_s1",  1, 2'b10, 3, 0, 0, 0, 1, 1, 0, 0, B(3));
    step("bp_f1",  1, 2'b10, 3, 0, 0, 0, 0, 1, 0, 0, B(3));
    step("bp_f2",  1, 2'b10, 3, 0, 0, 0, 0, 1, 0, 0, B(3));
    step("bp_s2",  1, 2'b10, 3, 0, 0, 0, 1, 1, 0, 0, B(3));
    step("bp_s3",  1, 2'b10, 3, 0, 0, 0, 1, 1, 0, 0, B(3));
    step("bp_iss", 1, 2'b10, 3, 0, 0, 0, 1, 0, 1, 1, 16'h0000);
    step("bp_nofire", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);

    // Reissue to r4 at cnt=1 restarts the full latency.
    step("rl_wr1", 1, 2'b00, 0, 0, 4, 1, 1, 0, 1, 1, 16'h0000);
    step("rl_i1",  0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1, B(4));
    step("rl_i2",  0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1, B(4));
    step("rl_wr2", 1, 2'b00, 0, 0, 4, 1, 1, 0, 1, 1, B(4));
    step("rl_s1",  1, 2'b10, 4, 0, 0, 0, 1, 1, 0, 0, B(4));
    step("rl_s2",  1, 2'b10, 4, 0, 0, 0, 1, 1, 0, 0, B(4));
    step("rl_s3",  1, 2'b10, 4, 0, 0, 0, 1, 1, 0, 0, B(4));
    step("rl_iss", 1, 2'b10, 4, 0, 0, 0, 1, 0, 1, 1, 16'h0000);

    // Self-dependent instruction issues, the next reader of r9 stalls.
    step("self",    1, 2'b10, 9, 0, 9, 1, 1, 0, 1, 1, 16'h0000);
    step("self_rd", 1, 2'b10, 9, 0, 0, 0, 1, 1, 0, 0, B(9));

    // Asynchronous reset between edges with r9 still pending.
    drive(1, 2'b10, 9, 0, 0, 0, 1);
    push_exp("pre_arst", 1'b1, 1'b0, 1'b0, B(9));
    #1;
    check_pop();
    #1;
    rst = 1'b0;
    sc_exp = 16'd0;
    #1;
    push_exp("arst", 1'b0, 1'b1, 1'b1, 16'h0000);
    check_pop();
    @(negedge clk);
    rst = 1'b1;
    step("post_arst", 1, 2'b10, 9, 0, 0, 0, 1, 0, 1, 1, 16'h0000);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
